jtkicker_colmix_n: RTL and testbench
====================================

# jtkicker_colmix_n

Parametrised colour mixer for the Kicker-family video pipeline: merges up to four tile/sprite layer pixels by priority, looks the winner up in a runtime-writable palette PROM image and drives blank-aligned RGB. It generalises the fixed two-layer mixer in two ways: configurable layer count and widths, and a selectable priority order. It sits after the scroll and object layers and feeds the video output stage with RGB plus delayed LHBL/LVBL.

## Interface
Parameters:
- LAYERS, 2, number of input layers (2..4); layer LAYERS-1 is top in normal priority
- PXLW, 4, bits per layer pixel
- LSELW, 1, layer-select bits, equals clog2(LAYERS)
- PALW, 5, palette address width, equals PXLW+LSELW
- BLANK_DLY, 9, pxl_cen delay applied to LHBL/LVBL; must be ≥3

Ports:
- clk  in  1  system clock (48 MHz); sole clock
- rst_n  in  1  reset, asynchronous, active-low
- pxl_cen  in  1  pixel clock enable
- layer_pxl  in  LAYERS*PXLW  layer pixels, layer k at [k*PXLW +: PXLW]
- gfx_en  in  LAYERS  per-layer enable (debug); 0 forces the layer transparent
- prio_mode  in  1  0 = highest layer index wins, 1 = reversed (layer 0 top)
- LHBL, LVBL  in  1  active-low blanking from the video timer
- prog_data  in  8  palette byte
- prog_addr  in  PALW  palette write address
- prog_en  in  1  palette write strobe
- red, green, blue  out  4  colour output
- LHBL_dly, LVBL_dly  out  1  delayed blanking

## Operation
- Pixel 0 of any layer is transparent; a layer with gfx_en[k]=0 counts as transparent.
- Priority scan runs from top to bottom per prio_mode. The first opaque layer wins: index = {k, pxl_k}.
- All layers transparent: the bottom layer wins with its raw pixel, or 0 if it is disabled. The resulting index is {bottom_id, pxl}, so bottom pixel 0 acts as backdrop.
- Palette: 2^PALW x 8 synchronous RAM, written with prog_en at clk rate regardless of pxl_cen.
- Byte format: [2:0] red, [5:3] green, [7:6] blue. Expansion is red={r,r[2]}, green={g,g[2]}, blue={b,b}.
- Output is zero when LHBL_dly or LVBL_dly is low.
- prio_mode and gfx_en are sampled at stage 1, like the pixels.

## Timing
- Pipeline advances only on pxl_cen; with pxl_cen low, all stages and outputs hold.
- S1: register layer_pxl, gfx_en, prio_mode.
- S2: priority select → registered index.
- S3: palette read → registered byte.
- S4 output: expand and blank → red/green/blue.
- Latency from layer_pxl to RGB is 3 pxl_cen.
- Blanking: BLANK_DLY-stage pxl_cen shift register on LHBL and LVBL. LHBL_dly/LVBL_dly change BLANK_DLY pxl_cen after their inputs.
- The colour blanking gate uses the same delayed signals, so RGB is forced to 0 on exactly the cycles where LHBL_dly & LVBL_dly is 0.
- Palette write and read to the same address in the same clk: the read returns the old byte; the new byte is visible on the next read.
- Reset (any time, asynchronous): pipeline registers go to 0, blank shift registers go to 0, RGB = 0, LHBL_dly = LVBL_dly = 0. Palette contents are not reset.
- After reset release, RGB stays 0 until BLANK_DLY pxl_cen of high blanking have propagated.

## Structure
- Shared package jtkicker_colmix_pkg holds:
  - the byte-field positions (R 2:0, G 5:3, B 7:6)
  - the transparent-pixel constant 0
  - the prio_mode encodings
- One sub-module: jtkicker_colmix_prio, a combinational LAYERS-way priority selector that outputs {lsel, pxl}. The parent instantiates it between S1 and S2.
- Palette RAM uses the existing dual-port RAM primitive: write port on prog_*, read port on the S2 index.

## Test plan
- Load: LAYERS=2, palette[0x13]=0x07, all others 0. Layer1=3, layer0=5, prio 0, blanking high → RGB = F,0,0 three pxl_cen later.
- Transparency: layer1=0, layer0=5, palette[0x05]=0xC0 → RGB = 0,0,F. With gfx_en=2'b10 instead → palette[0x00] is used.
- Reverse priority: LAYERS=4, layer3=2, layer0=1, prio_mode=1 → index 0x01 is selected; prio_mode=0 → index 0x32.
- Blank: LHBL pulsed low for 1 pxl_cen with BLANK_DLY=9 → LHBL_dly is low exactly 9 pxl_cen later for one pxl_cen, and RGB = 0 on that cycle only.
- Stall: hold pxl_cen low for 20 clk mid-line → RGB and the _dly outputs stay constant; resuming yields an unchanged pixel sequence.
- Reset mid-frame: drop rst_n asynchronously between clk edges → outputs go to 0 immediately. Palette writes made before reset are still read back after release.

Source files
------------

// File: rtl/jtkicker_colmix_pkg.sv
// Shared definitions for the Kicker colour mixer: palette byte layout,
// transparency value, priority-mode encodings and the RGB expansion helper.
package jtkicker_colmix_pkg;

  localparam int unsigned PAL_R_LSB = 0;
  localparam int unsigned PAL_R_MSB = 2;
  localparam int unsigned PAL_G_LSB = 3;
  localparam int unsigned PAL_G_MSB = 5;
  localparam int unsigned PAL_B_LSB = 6;
  localparam int unsigned PAL_B_MSB = 7;

  localparam int unsigned TRANSP_PXL = 0;

  typedef enum logic {
    PRIO_NORMAL  = 1'b0,
    PRIO_REVERSE = 1'b1
  } prio_mode_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // 3/3/2 palette byte to 4/4/4 colour, replicating the top bits into the LSBs
  function automatic rgb_t expand_pal(input logic [7:0] pal);
    rgb_t       c;
    logic [2:0] r3;
    logic [2:0] g3;
    logic [1:0] b2;
    r3  = pal[PAL_R_MSB:PAL_R_LSB];
    g3  = pal[PAL_G_MSB:PAL_G_LSB];
    b2  = pal[PAL_B_MSB:PAL_B_LSB];
    c.r = {r3, r3[2]};
    c.g = {g3, g3[2]};
    c.b = {b2, b2};
    return c;
  endfunction

endpackage

// File: rtl/jtkicker_colmix_prio.sv
// Combinational LAYERS-way priority selector: returns the winning layer id
// and its pixel, with the scan direction chosen by prio_mode.
module jtkicker_colmix_prio
  import jtkicker_colmix_pkg::*;
#(
  parameter int LAYERS = 2,
  parameter int PXLW   = 4,
  parameter int LSELW  = 1
) (
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic                   prio_mode,
  output logic [LSELW-1:0]       lsel,
  output logic [PXLW-1:0]        pxl
);

  localparam int IDXW = LSELW + PXLW;

  logic [LAYERS-1:0] opaque;
  logic [PXLW-1:0]   pxl_a  [LAYERS];
  logic [IDXW-1:0]   norm_c [LAYERS+1];
  logic [IDXW-1:0]   rev_c  [LAYERS+1];
  logic [IDXW-1:0]   win;

  // A transparent-but-enabled bottom pixel is 0 anyway, so the backdrop
  // pixel field is always 0 whether the bottom layer is enabled or not.
  assign norm_c[0]      = '0;
  assign rev_c[LAYERS]  = {LSELW'(LAYERS - 1), PXLW'(TRANSP_PXL)};

  for (genvar k = 0; k < LAYERS; k++) begin : g_layer
    assign pxl_a[k]    = layer_pxl[k*PXLW +: PXLW];
    assign opaque[k]   = gfx_en[k] && (pxl_a[k] != PXLW'(TRANSP_PXL));
    // normal chain: higher index overrides; reverse chain: lower index overrides
    assign norm_c[k+1] = opaque[k] ? {LSELW'(k), pxl_a[k]} : norm_c[k];
    assign rev_c[k]    = opaque[k] ? {LSELW'(k), pxl_a[k]} : rev_c[k+1];
  end

  always_comb begin
    win = norm_c[LAYERS];
    if (prio_mode == PRIO_REVERSE) begin
      win = rev_c[0];
    end
    lsel = win[IDXW-1:PXLW];
    pxl  = win[PXLW-1:0];
  end

endmodule

// File: rtl/jtkicker_colmix_n.sv
// Parametrised Kicker colour mixer: layer priority, palette lookup and
// blank-gated RGB output, all stages advancing on pxl_cen.
module jtkicker_colmix_n
  import jtkicker_colmix_pkg::*;
#(
  parameter int LAYERS    = 2,
  parameter int PXLW      = 4,
  parameter int LSELW     = 1,
  parameter int PALW      = 5,
  parameter int BLANK_DLY = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pxl_cen,
  input  logic [LAYERS*PXLW-1:0] layer_pxl,
  input  logic [LAYERS-1:0]      gfx_en,
  input  logic                   prio_mode,
  input  logic                   LHBL,
  input  logic                   LVBL,
  input  logic [7:0]             prog_data,
  input  logic [PALW-1:0]        prog_addr,
  input  logic                   prog_en,
  output logic [3:0]             red,
  output logic [3:0]             green,
  output logic [3:0]             blue,
  output logic                   LHBL_dly,
  output logic                   LVBL_dly
);

  logic [LAYERS*PXLW-1:0] pxl_d, pxl_q;
  logic [LAYERS-1:0]      en_d, en_q;
  logic                   mode_d, mode_q;
  logic [PALW-1:0]        idx_d, idx_q;
  logic [7:0]             pal_d, pal_q;
  logic [BLANK_DLY-1:0]   lhbl_sr_d, lhbl_sr_q;
  logic [BLANK_DLY-1:0]   lvbl_sr_d, lvbl_sr_q;

  logic [LSELW-1:0]       sel_lsel;
  logic [PXLW-1:0]        sel_pxl;
  logic [7:0]             pal_rd;
  logic [7:0]             pal_mem [2**PALW];
  rgb_t                   col;

  jtkicker_colmix_prio #(
    .LAYERS (LAYERS),
    .PXLW   (PXLW),
    .LSELW  (LSELW)
  ) u_prio (
    .layer_pxl (pxl_q),
    .gfx_en    (en_q),
    .prio_mode (mode_q),
    .lsel      (sel_lsel),
    .pxl       (sel_pxl)
  );

  // Palette is not reset; the write port runs at full clk rate.
  always_ff @(posedge clk) begin
    if (prog_en) begin
      pal_mem[prog_addr] <= prog_data;
    end
  end

  // Read happens before this edge's write lands, so a same-cycle
  // write/read to one address returns the old byte.
  assign pal_rd = pal_mem[idx_q];

  always_comb begin
    pxl_d     = pxl_q;
    en_d      = en_q;
    mode_d    = mode_q;
    idx_d     = idx_q;
    pal_d     = pal_q;
    lhbl_sr_d = lhbl_sr_q;
    lvbl_sr_d = lvbl_sr_q;
    if (pxl_cen) begin
      pxl_d     = layer_pxl;
      en_d      = gfx_en;
      mode_d    = prio_mode;
      idx_d     = {sel_lsel, sel_pxl};
      pal_d     = pal_rd;
      lhbl_sr_d = {lhbl_sr_q[BLANK_DLY-2:0], LHBL};
      lvbl_sr_d = {lvbl_sr_q[BLANK_DLY-2:0], LVBL};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pxl_q     <= '0;
      en_q      <= '0;
      mode_q    <= 1'b0;
      idx_q     <= '0;
      pal_q     <= '0;
      lhbl_sr_q <= '0;
      lvbl_sr_q <= '0;
    end else begin
      pxl_q     <= pxl_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      idx_q     <= idx_d;
      pal_q     <= pal_d;
      lhbl_sr_q <= lhbl_sr_d;
      lvbl_sr_q <= lvbl_sr_d;
    end
  end

  assign LHBL_dly = lhbl_sr_q[BLANK_DLY-1];
  assign LVBL_dly = lvbl_sr_q[BLANK_DLY-1];

  // Output stage is combinational off registered state, so it holds with
  // pxl_cen low and drops to 0 as soon as reset clears the blank registers.
  always_comb begin
    col   = expand_pal(pal_q);
    red   = '0;
    green = '0;
    blue  = '0;
    if (LHBL_dly && LVBL_dly) begin
      red   = col.r;
      green = col.g;
      blue  = col.b;
    end
  end

endmodule

// File: tb/tb_jtkicker_colmix_n.sv
// Self-checking bench for jtkicker_colmix_n with four layers.
module tb_jtkicker_colmix_n;

  localparam int LAYERS    = 4;
  localparam int PXLW      = 4;
  localparam int LSELW     = 2;
  localparam int PALW      = 6;
  localparam int BLANK_DLY = 9;
  localparam int HMAX      = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pxl_cen = 1'b0;
  logic [15:0] layer_pxl = '0;
  logic [3:0]  gfx_en = '0;
  logic        prio_mode = 1'b0;
  logic        LHBL = 1'b0;
  logic        LVBL = 1'b0;
  logic [7:0]  prog_data = '0;
  logic [5:0]  prog_addr = '0;
  logic        prog_en = 1'b0;
  logic [3:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  jtkicker_colmix_n #(
    .LAYERS    (LAYERS),
    .PXLW      (PXLW),
    .LSELW     (LSELW),
    .PALW      (PALW),
    .BLANK_DLY (BLANK_DLY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pxl_cen   (pxl_cen),
    .layer_pxl (layer_pxl),
    .gfx_en    (gfx_en),
    .prio_mode (prio_mode),
    .LHBL      (LHBL),
    .LVBL      (LVBL),
    .prog_data (prog_data),
    .prog_addr (prog_addr),
    .prog_en   (prog_en),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .LHBL_dly  (LHBL_dly),
    .LVBL_dly  (LVBL_dly)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  pal_m [64];
  int          idx_h [HMAX];
  bit          lh_h  [HMAX];
  bit          lv_h  [HMAX];
  int          nstep = 0;
  int          base = 0;
  logic [11:0] last_rgb = '0;
  logic [1:0]  last_blk = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First opaque layer in priority order wins; otherwise the bottom layer with pixel 0.
  function automatic int model_idx(input logic [15:0] pxls, input logic [3:0] en, input logic mode);
    int order [4];
    int l;
    int p;
    for (int i = 0; i < 4; i++) order[i] = mode ? i : 3 - i;
    for (int i = 0; i < 4; i++) begin
      l = order[i];
      p = int'((pxls >> (4 * l)) & 16'hF);
      if (en[l] && p != 0) return l * 16 + p;
    end
    return order[3] * 16;
  endfunction

  function automatic logic [11:0] expand(input int b);
    int r3, g3, b2;
    r3 = b & 7;
    g3 = (b >> 3) & 7;
    b2 = (b >> 6) & 3;
    return 12'(((r3 * 2 + r3 / 4) << 8) | ((g3 * 2 + g3 / 4) << 4) | (b2 * 5));
  endfunction

  function automatic int past_idx(input int m);
    return (m < base) ? 0 : idx_h[m];
  endfunction

  function automatic bit past_lh(input int m);
    return (m < base) ? 1'b0 : lh_h[m];
  endfunction

  function automatic bit past_lv(input int m);
    return (m < base) ? 1'b0 : lv_h[m];
  endfunction

  task automatic pal_wr(input int a, input int d);
    @(negedge clk);
    prog_en   = 1'b1;
    prog_addr = 6'(a);
    prog_data = 8'(d);
    @(posedge clk);
    @(negedge clk);
    prog_en = 1'b0;
    pal_m[a] = 8'(d);
  endtask

  task automatic step(input logic [15:0] pxls, input logic [3:0] en, input logic mode,
                      input logic lh, input logic lv, input bit wr, input int waddr, input int wdata);
    int   eb;
    bit   lhd, lvd;
    logic [11:0] erg;
    @(negedge clk);
    layer_pxl = pxls;
    gfx_en    = en;
    prio_mode = mode;
    LHBL      = lh;
    LVBL      = lv;
    prog_en   = wr;
    prog_addr = 6'(waddr);
    prog_data = 8'(wdata);
    pxl_cen   = 1'b1;
    if (nstep >= HMAX) $fatal(1, "FAIL history: step budget exceeded");
    idx_h[nstep] = model_idx(pxls, en, mode);
    lh_h[nstep]  = lh;
    lv_h[nstep]  = lv;
    eb  = int'(pal_m[past_idx(nstep - 2)]);
    lhd = past_lh(nstep - (BLANK_DLY - 1));
    lvd = past_lv(nstep - (BLANK_DLY - 1));
    if (wr) pal_m[waddr] = 8'(wdata);
    @(posedge clk);
    @(negedge clk);
    pxl_cen = 1'b0;
    prog_en = 1'b0;
    erg = (lhd && lvd) ? expand(eb) : 12'h000;
    last_rgb = erg;
    last_blk = {lhd, lvd};
    check("rgb", {20'h0, red, green, blue}, {20'h0, erg});
    check("blank_dly", {30'h0, LHBL_dly, LVBL_dly}, {30'h0, lhd, lvd});
    nstep++;
  endtask

  function automatic logic [3:0] rnd_pxl();
    return ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endfunction

  initial begin
    logic [15:0] rp;
    int          pulse_cnt;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rgb", {20'h0, red, green, blue}, 32'h0);
    check("reset_blank", {30'h0, LHBL_dly, LVBL_dly}, 32'h0);
    rst_n = 1'b1;

    for (int a = 0; a < 64; a++) pal_wr(a, 0);
    pal_wr(8'h13, 8'h07);

    // fill the blank delay line with active video
    for (int i = 0; i < BLANK_DLY; i++) step(16'h0000, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

    // layer1=3 over layer0=5 -> palette[0x13] = bright red
    for (int i = 0; i < 3; i++) step(16'h0035, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    check("load_red", {20'h0, red, green, blue}, 32'hF00);

    // transparency: layer0 shows through, then layer0 disabled -> backdrop palette[0]
    pal_wr(8'h05, 8'hC0);
    pal_wr(8'h00, 8'h38);
    for (int i = 0; i < 3; i++) step(16'h0005, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    check("transp_blue", {20'h0, red, green, blue}, 32'h00F);
    for (int i = 0; i < 3; i++) step(16'h0005, 4'b0010, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    check("disabled_backdrop", {20'h0, red, green, blue}, 32'h0F0);

    // priority direction: layer3=2, layer0=1
    pal_wr(8'h01, 8'h01);
    pal_wr(8'h32, 8'h08);
    for (int i = 0; i < 3; i++) step(16'h2001, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check("reverse_prio", {20'h0, red, green, blue}, 32'h200);
    for (int i = 0; i < 3; i++) step(16'h2001, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    check("normal_prio", {20'h0, red, green, blue}, 32'h020);

    // one-pxl_cen LHBL pulse appears BLANK_DLY stages later for exactly one pxl_cen
    step(16'h2001, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    pulse_cnt = 0;
    for (int i = 0; i < BLANK_DLY + 3; i++) begin
      step(16'h2001, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
      if (LHBL_dly == 1'b0) pulse_cnt++;
      if (i == BLANK_DLY - 2) check("pulse_rgb_zero", {20'h0, red, green, blue}, 32'h0);
    end
    check("pulse_width", pulse_cnt, 1);

    // same-clk palette write and read: old byte first, new byte next
    for (int i = 0; i < 3; i++) step(16'h0035, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    step(16'h0035, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 8'hC0);
    check("wr_rd_old", {20'h0, red, green, blue}, 32'hF00);
    step(16'h0035, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    check("wr_rd_new", {20'h0, red, green, blue}, 32'h00F);

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) begin
      rp = {rnd_pxl(), rnd_pxl(), rnd_pxl(), rnd_pxl()};
      step(rp, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 19) != 0),
           ($urandom_range(0, 7) == 0), int'($urandom_range(0, 63)), int'($urandom_range(0, 255)));
    end

    // stall: 20 clk with pxl_cen low, inputs wiggling
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      layer_pxl = 16'($urandom);
      LHBL      = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check("stall_rgb", {20'h0, red, green, blue}, {20'h0, last_rgb});
      check("stall_blank", {30'h0, LHBL_dly, LVBL_dly}, {30'h0, last_blk});
    end
    for (int i = 0; i < 20; i++) begin
      rp = {rnd_pxl(), rnd_pxl(), rnd_pxl(), rnd_pxl()};
      step(rp, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0, 0, 0);
    end

    // asynchronous reset between clock edges, palette retained
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_rgb", {20'h0, red, green, blue}, 32'h0);
    check("midreset_blank", {30'h0, LHBL_dly, LVBL_dly}, 32'h0);
    base = nstep;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < BLANK_DLY + 3; i++) step(16'h2001, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    check("retained_pal", {20'h0, red, green, blue}, {20'h0, expand(int'(pal_m[8'h01]))});
    for (int i = 0; i < 3; i++) step(16'h0035, 4'hF, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
    check("retained_pal2", {20'h0, red, green, blue}, {20'h0, expand(int'(pal_m[8'h13]))});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
